// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller and its queue.
package ifetch_ctrl_pkg;

  localparam logic [15:0] RESET_VECTOR = 16'h8000;

  // A queue entry holds the fetch address in the upper half and the word in the lower half.
  localparam int FETCH_ENTRY_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [FETCH_ENTRY_W-1:0] pack_entry(input logic [15:0] pc,
                                                          input logic [15:0] instr);
    return {pc, instr};
  endfunction

  function automatic logic [15:0] entry_pc(input logic [FETCH_ENTRY_W-1:0] entry);
    return entry[31:16];
  endfunction

  function automatic logic [15:0] entry_instr(input logic [FETCH_ENTRY_W-1:0] entry);
    return entry[15:0];
  endfunction

endpackage

// File: rtl/ifetch_ctrl_queue.sv
// Small FIFO holding fetched {pc, instr} pairs until decode takes them.
// Flush empties the queue and wins over any same-cycle push or pop.
module ifetch_queue
  import ifetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [FETCH_ENTRY_W-1:0] wdata_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [FETCH_ENTRY_W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FETCH_ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy updates; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  // Control registers cleared asynchronously so the queue comes out of reset empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset because count gates its visibility.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: steers the PC, issues one instruction-memory read at a
// time and buffers returned words for decode. Redirects flush the queue and
// any in-flight read is dropped when it eventually returns.
module ifetch_ctrl #(
  parameter int          DEPTH        = 2,
  parameter logic [15:0] RESET_VECTOR = ifetch_ctrl_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_addr_i,
  output logic        pc_write_o,
  output logic [15:0] pc_next_o,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [15:0] redirect_pc_i,
  output logic        dec_valid_o,
  output logic [15:0] dec_pc_o,
  output logic [15:0] dec_instr_o,
  input  logic        dec_ready_i
);

  import ifetch_ctrl_pkg::*;

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int CNTN_W = CNT_W + 1;

  fetch_state_e             state_q, state_d;
  logic                     imem_req_q, imem_req_d;
  logic [15:0]              imem_addr_q, imem_addr_d;
  logic [CNT_W-1:0]         count;
  logic [FETCH_ENTRY_W-1:0] head;
  logic [CNTN_W-1:0]        cnt_n;
  logic                     pop, push, space, issue;

  assign dec_valid_o = (count != '0);
  assign dec_pc_o    = entry_pc(head);
  assign dec_instr_o = entry_instr(head);
  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = imem_addr_q;

  // A new read is only allowed when the queue will still have room for its
  // result, which keeps count + outstanding within DEPTH at all times.
  assign pop   = dec_valid_o & dec_ready_i;
  assign push  = (state_q == BUSY) & imem_ack_i & ~redirect_valid_i;
  assign cnt_n = CNTN_W'(count) + CNTN_W'(push) - CNTN_W'(pop);
  assign space = (cnt_n < CNTN_W'(DEPTH));
  assign issue = ~redirect_valid_i & space &
                 ((state_q == IDLE) | ((state_q == BUSY) & imem_ack_i));

  // Next state, request register updates and combinational PC steering.
  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    pc_write_o  = 1'b1;
    pc_next_o   = pc_addr_i;

    case (state_q)
      IDLE: begin
        if (issue) state_d = BUSY;
      end
      BUSY: begin
        if (redirect_valid_i) state_d = imem_ack_i ? IDLE : DISCARD;
        else if (imem_ack_i)  state_d = issue ? BUSY : IDLE;
      end
      DISCARD: begin
        // The ack retires the dropped read even if another redirect arrives with it.
        if (imem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      imem_req_d  = 1'b1;
      imem_addr_d = pc_addr_i;
    end else if (imem_ack_i && (state_q != IDLE)) begin
      imem_req_d = 1'b0;
    end

    // Letting the PC increment on issue means each issued address consumes
    // exactly one PC value; otherwise the PC is held or redirected.
    if (redirect_valid_i) begin
      pc_write_o = 1'b1;
      pc_next_o  = {redirect_pc_i[15:1], 1'b0};
    end else if (issue) begin
      pc_write_o = 1'b0;
    end
  end

  // State and request registers, reset asynchronously to the boot vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_VECTOR;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  ifetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .wdata_i (pack_entry(imem_addr_q, imem_rdata_i)),
    .count_o (count),
    .head_o  (head)
  );

  // The issue rule must never let a result arrive into a full queue.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_ifetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pcAddr;
  logic        pcWrite;
  logic [15:0] pcNext;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemRdata;
  logic        redirValid;
  logic [15:0] redirPc;
  logic        decValid;
  logic [15:0] decPc;
  logic [15:0] decInstr;
  logic        decReady;

  int testsRun = 0;
  int failures = 0;

  int delayQ[$];

  ifetch_ctrl #(
    .DEPTH(DEPTH),
    .RESET_VECTOR(16'h8000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_addr_i        (pcAddr),
    .pc_write_o       (pcWrite),
    .pc_next_o        (pcNext),
    .imem_req_o       (imemReq),
    .imem_addr_o      (imemAddr),
    .imem_ack_i       (imemAck),
    .imem_rdata_i     (imemRdata),
    .redirect_valid_i (redirValid),
    .redirect_pc_i    (redirPc),
    .dec_valid_o      (decValid),
    .dec_pc_o         (decPc),
    .dec_instr_o      (decInstr),
    .dec_ready_i      (decReady)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Program counter the controller steers: load when asked, otherwise step by 2.
  always @(posedge clk or posedge rst) begin
    if (rst)          pcAddr <= 16'h8000;
    else if (pcWrite) pcAddr <= pcNext;
    else              pcAddr <= pcAddr + 16'd2;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    decReady   = rdy;
    redirValid = rv;
    redirPc    = rpc;
    @(negedge clk);
  endtask

  task automatic assertReset();
    @(posedge clk);
    #3 rst = 1'b1;
    delayQ.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic releaseReset();
    #3 rst = 1'b0;
    @(negedge clk);
  endtask

  // Memory responder: each request is acked after a delay taken from delayQ,
  // or a random 0..3 cycles; the returned word is 0x1000 + address.
  initial begin
    int memWait;
    memWait   = -1;
    imemAck   = 1'b0;
    imemRdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        memWait = -1;
        imemAck = 1'b0;
      end else begin
        if (imemAck) memWait = -1;
        if (imemReq && memWait < 0) begin
          if (delayQ.size() != 0) memWait = delayQ.pop_front();
          else                    memWait = $urandom_range(0, 3);
        end
        imemAck = imemReq && (memWait == 0);
        if (!imemAck && memWait > 0) memWait--;
      end
      imemRdata = imemAck ? (16'h1000 + imemAddr) : 16'hDEAD;
    end
  end

  // Reference model: expected decode stream as a queue, one in-flight read
  // flagged kept or dropped, and the next PC value that must be fetched.
  initial begin
    logic [31:0] mq[$];
    logic        mOut, mKept, ack, pop, push, issue;
    logic [15:0] expAddr, nextFetch;
    int          cntN;
    mOut = 0; mKept = 0; expAddr = 16'h8000; nextFetch = 16'h8000;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        mOut = 0; mKept = 0;
        expAddr   = 16'h8000;
        nextFetch = 16'h8000;
      end else begin
        checkOutput("m_dec_valid", 32'(decValid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
          checkOutput("m_dec_pc", 32'(decPc), 32'(mq[0][31:16]));
          checkOutput("m_dec_instr", 32'(decInstr), 32'(mq[0][15:0]));
        end
        checkOutput("m_imem_req", 32'(imemReq), 32'(mOut));
        checkOutput("m_imem_addr", 32'(imemAddr), 32'(expAddr));
        checkOutput("m_pc_addr", 32'(pcAddr), 32'(nextFetch));

        ack   = imemAck && mOut;
        pop   = (mq.size() != 0) && decReady;
        push  = mOut && mKept && ack && !redirValid;
        cntN  = mq.size() + int'(push) - int'(pop);
        issue = !redirValid && (cntN < DEPTH) && (!mOut || (mKept && ack));

        if (redirValid) begin
          checkOutput("m_pc_write_redir", 32'(pcWrite), 32'd1);
          checkOutput("m_pc_next_redir", 32'(pcNext), 32'({redirPc[15:1], 1'b0}));
        end else if (issue) begin
          checkOutput("m_pc_write_issue", 32'(pcWrite), 32'd0);
        end else begin
          checkOutput("m_pc_write_hold", 32'(pcWrite), 32'd1);
          checkOutput("m_pc_next_hold", 32'(pcNext), 32'(pcAddr));
        end

        if (redirValid) mq.delete();
        else begin
          if (pop)  void'(mq.pop_front());
          if (push) mq.push_back({expAddr, 16'h1000 + expAddr});
        end

        if (issue) begin
          mOut = 1; mKept = 1; expAddr = pcAddr;
        end else if (ack) begin
          mOut = 0;
        end else if (redirValid && mOut) begin
          mKept = 0;
        end

        if (redirValid) nextFetch = {redirPc[15:1], 1'b0};
        else if (issue) nextFetch = nextFetch + 16'd2;
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, expected finish before 500000");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    rst = 1'b1; decReady = 1'b0; redirValid = 1'b0; redirPc = 16'h0000;
    repeat (3) @(posedge clk);

    // Back-to-back fetch with single-cycle acks.
    delayQ = '{0, 0, 0};
    decReady = 1'b1;
    releaseReset();
    checkOutput("t1_reset_req", 32'(imemReq), 32'd0);
    checkOutput("t1_reset_addr", 32'(imemAddr), 32'h8000);
    checkOutput("t1_reset_valid", 32'(decValid), 32'd0);
    checkOutput("t1_c0_pc_write", 32'(pcWrite), 32'd0);
    applyStimulus(1, 0, 16'h0);
    checkOutput("t1_c1_addr", 32'(imemAddr), 32'h8000);
    checkOutput("t1_c1_req", 32'(imemReq), 32'd1);
    applyStimulus(1, 0, 16'h0);
    checkOutput("t1_c2_addr", 32'(imemAddr), 32'h8002);
    checkOutput("t1_c2_dec_pc", 32'(decPc), 32'h8000);
    checkOutput("t1_c2_dec_instr", 32'(decInstr), 32'h9000);
    applyStimulus(1, 0, 16'h0);
    checkOutput("t1_c3_addr", 32'(imemAddr), 32'h8004);
    checkOutput("t1_c3_dec_pc", 32'(decPc), 32'h8002);
    checkOutput("t1_c3_dec_instr", 32'(decInstr), 32'h9002);

    // Decode stalled: queue fills, request stops, PC held at 0x8004.
    assertReset();
    delayQ = '{0, 0, 0};
    decReady = 1'b0;
    releaseReset();
    applyStimulus(0, 0, 16'h0);
    applyStimulus(0, 0, 16'h0);
    applyStimulus(0, 0, 16'h0);
    checkOutput("t2_full_req", 32'(imemReq), 32'd0);
    checkOutput("t2_full_pc_write", 32'(pcWrite), 32'd1);
    checkOutput("t2_full_pc_next", 32'(pcNext), 32'h8004);
    checkOutput("t2_full_head", 32'(decPc), 32'h8000);
    applyStimulus(1, 0, 16'h0);
    checkOutput("t2_resume_pc_write", 32'(pcWrite), 32'd0);
    applyStimulus(1, 0, 16'h0);
    checkOutput("t2_resume_addr", 32'(imemAddr), 32'h8004);
    checkOutput("t2_resume_req", 32'(imemReq), 32'd1);

    // Slow ack, redirect during an outstanding read, redirect with ack and pop.
    assertReset();
    delayQ = '{0, 3, 3, 0, 0};
    decReady = 1'b1;
    releaseReset();
    applyStimulus(1, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 16'h0);
      checkOutput("t3_stall_addr", 32'(imemAddr), 32'h8002);
      checkOutput("t3_stall_ack", 32'(imemAck), 32'd0);
      checkOutput("t3_stall_pc_write", 32'(pcWrite), 32'd1);
      checkOutput("t3_stall_pc_next", 32'(pcNext), 32'h8004);
    end
    applyStimulus(0, 0, 16'h0);
    checkOutput("t3_ack", 32'(imemAck), 32'd1);
    applyStimulus(0, 1, 16'h9001);
    checkOutput("t4_redir_pc_next", 32'(pcNext), 32'h9000);
    checkOutput("t4_redir_addr", 32'(imemAddr), 32'h8004);
    checkOutput("t4_redir_head", 32'(decPc), 32'h8002);
    applyStimulus(0, 0, 16'h0);
    checkOutput("t4_flushed", 32'(decValid), 32'd0);
    checkOutput("t4_pc_held", 32'(pcAddr), 32'h9000);
    checkOutput("t4_discard_pc_write", 32'(pcWrite), 32'd1);
    applyStimulus(0, 0, 16'h0);
    applyStimulus(0, 0, 16'h0);
    checkOutput("t4_late_ack", 32'(imemAck), 32'd1);
    applyStimulus(0, 0, 16'h0);
    checkOutput("t4_dropped", 32'(decValid), 32'd0);
    checkOutput("t4_idle_req", 32'(imemReq), 32'd0);
    applyStimulus(0, 0, 16'h0);
    checkOutput("t4_target_addr", 32'(imemAddr), 32'h9000);
    applyStimulus(1, 1, 16'hA000);
    checkOutput("t5_ack", 32'(imemAck), 32'd1);
    checkOutput("t5_head", 32'(decPc), 32'h9000);
    checkOutput("t5_pc_next", 32'(pcNext), 32'hA000);
    applyStimulus(0, 0, 16'h0);
    checkOutput("t5_empty", 32'(decValid), 32'd0);
    checkOutput("t5_idle_req", 32'(imemReq), 32'd0);
    applyStimulus(0, 0, 16'h0);
    checkOutput("t5_target_addr", 32'(imemAddr), 32'hA000);

    // Reset while a read is outstanding.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_req", 32'(imemReq), 32'd0);
    checkOutput("t6_addr", 32'(imemAddr), 32'h8000);
    checkOutput("t6_valid", 32'(decValid), 32'd0);
    delayQ.delete();
    repeat (2) @(posedge clk);
    releaseReset();
    applyStimulus(1, 0, 16'h0);
    checkOutput("t6_restart_addr", 32'(imemAddr), 32'h8000);
    checkOutput("t6_restart_req", 32'(imemReq), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(logic'($urandom_range(0, 9) < 7),
                    logic'($urandom_range(0, 19) == 0),
                    16'($urandom));
    end
    applyStimulus(1, 0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
